// File: rtl/wb_pkg.sv
// Shared types and widths for the writeback stage.
//   XLEN        result / register-file write data width
//   REG_ADDR_W  register index width
//   CNT_W       width of the ALU starvation counter
//   wb_req_t    one producer's offered result {valid, rd, data}
//   wb_pri_e    tie-break priority state of the arbiter
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = 4;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic {
    LSU_PRI = 1'b0,
    ALU_PRI = 1'b1
  } wb_pri_e;

  // Saturating increment for the starvation counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU and LSU results onto the single register-file
// write port. The accepted result is registered and presented one cycle later;
// the registered result doubles as the operand-forwarding bypass.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data     ALU result offer
//   alu_ready                     ALU result accepted this cycle (combinational)
//   lsu_valid/lsu_rd/lsu_data     load result offer
//   lsu_ready                     load result accepted this cycle (combinational)
//   reg_write/rd_addr/rd_data     registered register-file write port
//   bypass_valid                  forwarding qualifier, equal to reg_write
//
// state   | meaning
// LSU_PRI | LSU wins ties; consecutive ALU stalls are counted
// ALU_PRI | ALU wins ties until its next accept
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] rd_addr,
  output logic [XLEN-1:0]       rd_data,
  output logic                  bypass_valid
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  wb_req_t alu_req;
  wb_req_t lsu_req;

  logic grant_alu;
  logic grant_lsu;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;

  wb_pri_e               pri_q,       pri_d;
  logic [CNT_W-1:0]      wait_cnt_q,  wait_cnt_d;
  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] rd_addr_q,   rd_addr_d;
  logic [XLEN-1:0]       rd_data_q,   rd_data_d;

  assign alu_req = '{valid: alu_valid, rd: alu_rd, data: alu_data};
  assign lsu_req = '{valid: lsu_valid, rd: lsu_rd, data: lsu_data};

  always_comb begin
    // The write port never stalls, so a lone requester is always granted.
    grant_alu = alu_req.valid && (!lsu_req.valid || pri_q == ALU_PRI);
    grant_lsu = lsu_req.valid && !grant_alu;

    sel_rd   = grant_alu ? alu_req.rd   : lsu_req.rd;
    sel_data = grant_alu ? alu_req.data : lsu_req.data;

    pri_d      = pri_q;
    wait_cnt_d = wait_cnt_q;
    if (grant_alu) begin
      wait_cnt_d = '0;
      pri_d      = LSU_PRI;
    end else if (!alu_req.valid) begin
      // Only consecutive stalls count toward starvation.
      wait_cnt_d = '0;
    end else begin
      wait_cnt_d = sat_inc(wait_cnt_q);
      // Switch on the same edge the count reaches the limit, so the very
      // next cycle the ALU wins the tie (LIMIT LSU grants, then one ALU).
      if (pri_q == LSU_PRI && wait_cnt_d >= LIMIT) begin
        pri_d = ALU_PRI;
      end
    end

    // x0 results are consumed but never written.
    reg_write_d = (grant_alu || grant_lsu) && (sel_rd != '0);
    rd_addr_d   = rd_addr_q;
    rd_data_d   = rd_data_q;
    if (grant_alu || grant_lsu) begin
      rd_addr_d = sel_rd;
      rd_data_d = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri_q       <= LSU_PRI;
      wait_cnt_q  <= '0;
      reg_write_q <= 1'b0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
    end else begin
      pri_q       <= pri_d;
      wait_cnt_q  <= wait_cnt_d;
      reg_write_q <= reg_write_d;
      rd_addr_q   <= rd_addr_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Grants are suppressed while reset is held so no producer sees a
  // handshake that the cleared output registers would then drop.
  assign alu_ready    = grant_alu && rst_n;
  assign lsu_ready    = grant_lsu && rst_n;

  assign reg_write    = reg_write_q;
  assign bypass_valid = reg_write_q;
  assign rd_addr      = rd_addr_q;
  assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;
  import wb_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  alu_valid = 1'b0;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd = '0;
  logic [XLEN-1:0]       alu_data = '0;
  logic                  lsu_valid = 1'b0;
  logic                  lsu_ready;
  logic [REG_ADDR_W-1:0] lsu_rd = '0;
  logic [XLEN-1:0]       lsu_data = '0;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic [XLEN-1:0]       rd_data;
  logic                  bypass_valid;

  writeback_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .reg_write    (reg_write),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .bypass_valid (bypass_valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic                  we;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } exp_t;

  exp_t sb[$];

  // Reference model of the arbiter priority and output hold registers.
  int                    m_pri;
  int                    m_cnt;
  logic [REG_ADDR_W-1:0] m_addr;
  logic [XLEN-1:0]       m_data;

  int a_seq;
  int l_seq;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pri  = 0;
    m_cnt  = 0;
    m_addr = '0;
    m_data = '0;
    sb.delete();
  endtask

  // Called at posedge+1: drives one cycle of offers, checks grants, pushes the
  // expected write, then after the edge pops and checks the output registers.
  task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                       output logic obs_a, output logic obs_l);
    logic ga, gl;
    exp_t e;
    alu_valid = av; alu_rd = ar; alu_data = ad;
    lsu_valid = lv; lsu_rd = lr; lsu_data = ld;
    #1;
    ga = av && (!lv || m_pri == 1);
    gl = lv && !ga;
    obs_a = alu_ready;
    obs_l = lsu_ready;
    check_eq("alu_ready", alu_ready, ga);
    check_eq("lsu_ready", lsu_ready, gl);
    e.we = 1'b0;
    if (ga || gl) begin
      m_addr = ga ? ar : lr;
      m_data = ga ? ad : ld;
      e.we   = (m_addr != 0);
    end
    e.addr = m_addr;
    e.data = m_data;
    sb.push_back(e);
    if (ga) begin
      m_cnt = 0;
      m_pri = 0;
    end else if (!av) begin
      m_cnt = 0;
    end else begin
      if (m_cnt < 15) m_cnt++;
      if (m_pri == 0 && m_cnt >= 4) m_pri = 1;
    end
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check_eq("reg_write", reg_write, e.we);
      check_eq("bypass_valid", bypass_valid, e.we);
      check_eq("rd_addr", rd_addr, e.addr);
      check_eq("rd_data", rd_data, e.data);
    end
  endtask

  task automatic idle(input int n);
    logic oa, ol;
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, oa, ol);
  endtask

  function automatic logic [4:0] seq_rd(input int s);
    return 5'((s % 31) + 1);
  endfunction

  // Both producers valid every cycle; returns a bit per cycle, 1 = ALU granted.
  task automatic both_run(input int n, output logic [31:0] alu_hits);
    logic oa, ol;
    alu_hits = '0;
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, seq_rd(a_seq), 32'hA000_0000 + 32'(a_seq),
            1'b1, seq_rd(l_seq), 32'h5000_0000 + 32'(l_seq), oa, ol);
      alu_hits[i] = oa;
      if (oa) a_seq++;
      if (ol) l_seq++;
    end
  endtask

  initial begin
    logic oa, ol;
    logic [31:0] hits;
    logic [31:0] pat;
    logic        a_pend, l_pend;
    logic [4:0]  a_r, l_r;
    logic [31:0] a_d, l_d;

    a_seq = 0;
    l_seq = 0;
    model_reset();

    // Reset values with offers present.
    alu_valid = 1'b1; lsu_valid = 1'b1;
    #2;
    check_eq("rst_reg_write", reg_write, 0);
    check_eq("rst_rd_addr", rd_addr, 0);
    check_eq("rst_rd_data", rd_data, 0);
    check_eq("rst_alu_ready", alu_ready, 0);
    check_eq("rst_lsu_ready", lsu_ready, 0);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // ALU only.
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, oa, ol);
    check_eq("t2_alu_grant", oa, 1);
    check_eq("t2_rd_addr", rd_addr, 5);
    check_eq("t2_rd_data", rd_data, 32'hDEADBEEF);
    idle(1);
    check_eq("t2_bubble_hold", rd_data, 32'hDEADBEEF);

    // Tie, LSU priority first.
    cycle(1'b1, 5'd7, 32'h22, 1'b1, 5'd3, 32'h11, oa, ol);
    check_eq("t3_lsu_grant", ol, 1);
    check_eq("t3_rd_addr", rd_addr, 3);
    cycle(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'd0, oa, ol);
    check_eq("t3_alu_after", rd_addr, 7);

    // Starvation: 4 LSU then 1 ALU, repeating.
    pat = 32'b100001000010000;
    both_run(15, hits);
    check_eq("t4_pattern", hits & 32'h7FFF, pat);
    idle(1);

    // Stall run broken by alu_valid=0 restarts the count.
    both_run(3, hits);
    check_eq("t4b_first3", hits & 32'h7, 0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, seq_rd(l_seq), 32'h5000_0000 + 32'(l_seq), oa, ol);
    if (ol) l_seq++;
    both_run(5, hits);
    check_eq("t4b_restart", hits & 32'h1F, 32'b10000);
    idle(1);

    // x0 result consumed, not written; then rd=9 writes.
    cycle(1'b1, 5'd0, 32'hCAFE0000, 1'b0, 5'd0, 32'd0, oa, ol);
    check_eq("t5_x0_ready", oa, 1);
    check_eq("t5_x0_no_write", reg_write, 0);
    cycle(1'b1, 5'd9, 32'h00001234, 1'b0, 5'd0, 32'd0, oa, ol);
    check_eq("t5_rd9_write", reg_write, 1);
    idle(1);

    // Back-to-back LSU for 8 cycles, no bubble.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'(10 + i), 32'hB000_0000 + 32'(i), oa, ol);
      check_eq("t6_no_bubble", reg_write, 1);
    end
    idle(1);

    // Random traffic with hold-until-accepted sources.
    a_pend = 1'b0; l_pend = 1'b0;
    a_r = '0; l_r = '0; a_d = '0; l_d = '0;
    for (int i = 0; i < 60; i++) begin
      if (!a_pend && $urandom_range(0, 3) != 0) begin
        a_pend = 1'b1; a_r = 5'($urandom_range(0, 31)); a_d = $urandom;
      end
      if (!l_pend && $urandom_range(0, 3) != 0) begin
        l_pend = 1'b1; l_r = 5'($urandom_range(0, 31)); l_d = $urandom;
      end
      cycle(a_pend, a_r, a_d, l_pend, l_r, l_d, oa, ol);
      if (oa) a_pend = 1'b0;
      if (ol) l_pend = 1'b0;
    end

    // Reset asserted mid-traffic with a grant in flight.
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h77;
    lsu_valid = 1'b1; lsu_rd = 5'd13; lsu_data = 32'h88;
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("t1_reg_write", reg_write, 0);
    check_eq("t1_bypass", bypass_valid, 0);
    check_eq("t1_rd_addr", rd_addr, 0);
    check_eq("t1_rd_data", rd_data, 0);
    check_eq("t1_alu_ready", alu_ready, 0);
    check_eq("t1_lsu_ready", lsu_ready, 0);
    model_reset();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    idle(1);
    cycle(1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, oa, ol);
    check_eq("t1_post_lsu_pri", ol, 1);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
